// File: rtl/mac_accumulator.sv
// Frame accumulator for the dual-product MAC: sums cfg_len unsigned terms into a
// saturating wide accumulator and presents each frame result on a registered valid/ready port.
module mac_accumulator #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned ACC_W = 40,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic [ACC_W-1:0]   in_ext;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   sat_acc;
    logic               sat_ovf;
    logic [LEN_W-1:0]   first_len;
    logic [LEN_W-1:0]   cnt_inc;

    assign in_ready  = (state_q != S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

    // Add is one bit wider than the accumulator so the carry drives saturation.
    assign accept    = in_valid && in_ready;
    assign in_ext    = ACC_W'(in_data);
    assign sum       = SUM_W'(acc_q) + SUM_W'(in_ext);
    assign sat_acc   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    assign sat_ovf   = ovf_q | sum[ACC_W];
    assign first_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign cnt_inc   = cnt_q + LEN_W'(1);

    // Next-state logic; the final sum is written straight into the output register on DONE entry.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d = in_ext;
                    cnt_d = LEN_W'(1);
                    len_d = first_len;
                    ovf_d = 1'b0;
                    if (first_len == LEN_W'(1)) begin
                        state_d     = S_DONE;
                        out_data_d  = in_ext;
                        out_ovf_d   = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = sat_acc;
                    ovf_d = sat_ovf;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d     = S_DONE;
                        out_data_d  = sat_acc;
                        out_ovf_d   = sat_ovf;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream stage of the 8-bit dual-product MAC datapath.
- Consumes the 32-bit per-cycle dot-product term (a*b + c*d, unsigned) over a valid/ready stream.
- Sums a configurable number of consecutive terms into one wide unsigned accumulator, then presents the frame result with a sticky overflow flag on a registered valid/ready output.
- Sits between the combinational MAC and the AXI-Lite register/readback logic of the same IP.

Parameters:
- IN_W, 32, width of the incoming term (zero-extended into the accumulator).
- ACC_W, 40, accumulator and result width; must be >= IN_W.
- LEN_W, 16, width of the frame-length configuration and the term counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_len  input  LEN_W  number of terms per frame; 0 is treated as 1; sampled only on the first beat of a frame.
- in_data  input  IN_W  term from the MAC stage, unsigned.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  ACC_W  frame sum, registered.
- out_ovf  output  1  sum saturated during this frame.
- out_valid  output  1  out_data/out_ovf are valid.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  a frame is in progress or a result is pending.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE; acc, cnt, len_q, out_data all 0.
  - out_ovf=0, out_valid=0, busy=0, in_ready=1 (combinational from state).
  - Any partial frame is discarded.
- A beat is accepted when in_valid && in_ready at a rising edge.
- States:
  - IDLE: in_ready=1, busy=0. On accept:
    - acc<=zext(in_data), cnt<=1, len_q<=max(cfg_len,1), ovf<=0.
    - If max(cfg_len,1)==1, go to DONE; else go to ACCUM.
  - ACCUM: in_ready=1, busy=1. On accept:
    - acc<=sat(acc+zext(in_data)), cnt<=cnt+1.
    - When cnt+1==len_q, go to DONE.
    - No accept means hold; in_valid gaps are allowed with no timeout.
  - DONE: entry cycle loads out_data<=final acc and out_ovf<=ovf, and sets out_valid=1.
    - in_ready=0, busy=1.
    - Hold all outputs stable until out_valid && out_ready, then go to IDLE and clear out_valid.
    - A new frame can start on the following cycle.
- Latency: out_valid rises on the clock edge after the last term is accepted.
  - Result appears 1 cycle after the last accept; the effective pipeline is the DONE entry register.
- Throughput: one term per clock within a frame. Minimum one-cycle gap between frames (the DONE handshake cycle).
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - If the carry bit is set, acc<=all ones and ovf<=1 (sticky for the frame).
  - Further adds keep acc at all ones.
- cfg_len changes mid-frame are ignored (len_q is latched).
- A new cfg_len takes effect only on the first beat of the next frame.
- Counter: cnt never wraps. len_q<=2^LEN_W-1 is guaranteed by the width, and the DONE transition precedes any wrap.
- Simultaneous out_ready and in_valid in DONE: the result is consumed, the input is not accepted (in_ready=0), and the input is accepted next cycle in IDLE.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Basic frame:
  - cfg_len=4, in_data=10,20,30,40 on consecutive cycles with out_ready=1.
  - -> out_data=100, out_ovf=0, out_valid high exactly 1 cycle after the 4th accept, for 1 cycle.
- Length edge:
  - cfg_len=0, then a single beat 0x0001FC02 (255*255+255*255=130050).
  - -> out_data=130050 one cycle later.
  - Then cfg_len=1 with 7 -> out_data=7.
- Backpressure and bubbles:
  - cfg_len=3, in_valid toggled 1,0,1,0,1 with data 5,6,7; out_ready held 0 for 5 cycles.
  - -> out_data=18, stable while out_valid=1, in_ready=0 throughout DONE.
  - The next frame is accepted only the cycle after out_ready=1.
- Saturation with ACC_W=33:
  - cfg_len=3, in_data=0xFFFFFFFF x3.
  - -> out_data=0x1FFFFFFFF, out_ovf=1.
  - The following frame (cfg_len=1, data 1) -> out_ovf=0, out_data=1.
- Mid-frame reset and config change:
  - cfg_len=5; accept 2 beats; change cfg_len to 2; accept 3 beats (5 total, the frame completes on len_q=5).
  - Then in a new frame, assert rst after 1 beat.
  - -> rst immediately drives out_valid=0, busy=0, in_ready=1.
  - Next frame cfg_len=2 with 3,4 -> out_data=7.
